// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port word memory.
// One transaction in flight; reads wait a fixed RD_LAT, misaligned accesses never reach memory.
module mem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [2:0] CNT_LOAD = 3'(RD_LAT - 1);

  state_t          state_r, state_s;
  logic            grant_s, sel_s, mis_s;
  logic            sel_we_s;
  logic [AW-1:0]   sel_adr_s;
  logic [DW-1:0]   sel_wdata_s;
  logic            resp_owner_s, resp_err_s;
  logic            last_owner_r, owner_r, mis_r, busy_r;
  logic [2:0]      cnt_r;
  logic            m0_ack_r, m0_err_r, m1_ack_r, m1_err_r;
  logic [DW-1:0]   m0_rdata_r, m1_rdata_r;
  logic            mem_en_r, mem_we_r;
  logic [AW-1:0]   mem_adr_r;
  logic [DW-1:0]   mem_wdata_r;

  // Requester selection, next state, and the owner/err that a RESP entered this cycle reports
  always_comb begin
    state_s = state_r;
    grant_s = 1'b0;
    if (m0_req && m1_req) begin
      sel_s = ~last_owner_r;
    end else if (m1_req) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
    sel_we_s    = sel_s ? m1_we    : m0_we;
    sel_adr_s   = sel_s ? m1_adr   : m0_adr;
    sel_wdata_s = sel_s ? m1_wdata : m0_wdata;
    mis_s       = (sel_adr_s[1:0] != 2'b00);

    case (state_r)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          grant_s = 1'b1;
          state_s = mis_s ? S_RESP : S_ACCESS;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ACCESS: state_s = mem_we_r ? S_RESP : S_WAIT;
      S_WAIT: begin
        if (cnt_r == 3'd0) begin
          state_s = S_RESP;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_RESP:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase

    resp_owner_s = grant_s ? sel_s : owner_r;
    resp_err_s   = grant_s ? mis_s : mis_r;
  end

  // State, latched request, and every output register (outputs track the state being entered)
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      last_owner_r <= 1'b1;
      owner_r      <= 1'b0;
      mis_r        <= 1'b0;
      busy_r       <= 1'b0;
      cnt_r        <= 3'd0;
      m0_ack_r     <= 1'b0;
      m0_err_r     <= 1'b0;
      m1_ack_r     <= 1'b0;
      m1_err_r     <= 1'b0;
      m0_rdata_r   <= '0;
      m1_rdata_r   <= '0;
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_adr_r    <= '0;
      mem_wdata_r  <= '0;
    end else begin
      state_r <= state_s;
      if (grant_s) begin
        owner_r      <= sel_s;
        last_owner_r <= sel_s;
        mis_r        <= mis_s;
      end
      // Memory-side fields only move for accesses that actually reach memory
      if (grant_s && !mis_s) begin
        mem_we_r    <= sel_we_s;
        mem_adr_r   <= sel_adr_s;
        mem_wdata_r <= sel_wdata_s;
      end
      mem_en_r <= (state_s == S_ACCESS);
      if ((state_r == S_ACCESS) && (state_s == S_WAIT)) begin
        cnt_r <= CNT_LOAD;
      end else if ((state_r == S_WAIT) && (cnt_r != 3'd0)) begin
        cnt_r <= cnt_r - 3'd1;
      end
      if ((state_r == S_WAIT) && (cnt_r == 3'd0)) begin
        if (owner_r) begin
          m1_rdata_r <= mem_rdata;
        end else begin
          m0_rdata_r <= mem_rdata;
        end
      end
      m0_ack_r <= (state_s == S_RESP) && !resp_owner_s;
      m1_ack_r <= (state_s == S_RESP) &&  resp_owner_s;
      m0_err_r <= (state_s == S_RESP) && !resp_owner_s && resp_err_s;
      m1_err_r <= (state_s == S_RESP) &&  resp_owner_s && resp_err_s;
      busy_r   <= (state_s != S_IDLE);
    end
  end

  assign m0_ack    = m0_ack_r;
  assign m0_err    = m0_err_r;
  assign m0_rdata  = m0_rdata_r;
  assign m1_ack    = m1_ack_r;
  assign m1_err    = m1_err_r;
  assign m1_rdata  = m1_rdata_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_adr   = mem_adr_r;
  assign mem_wdata = mem_wdata_r;
  assign owner     = owner_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, hold-request sequences, mid-read reset,
// and random traffic checked against a transaction-level model with its own memory image.
module tb_mem_port_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_adr, m0_wdata, m1_adr, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we, owner, busy;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_pat(input int i);
    if (i == 4) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 + i;
  endfunction

  // Memory device: 64 words, reads return data LAT cycles after the strobe, junk otherwise
  logic [31:0] dev_mem [64];
  logic [31:0] pipe [LAT];
  logic        pv [LAT];
  bit          dev_init;
  always @(posedge clk) begin
    if (!dev_init) begin
      for (int i = 0; i < 64; i++) dev_mem[i] <= init_pat(i);
      dev_init <= 1'b1;
    end else if (mem_en && mem_we) begin
      dev_mem[mem_adr[7:2]] <= mem_wdata;
    end
    pipe[0] <= dev_mem[mem_adr[7:2]];
    pv[0]   <= mem_en && !mem_we;
    for (int i = 1; i < LAT; i++) begin
      pipe[i] <= pipe[i-1];
      pv[i]   <= pv[i-1];
    end
  end
  assign mem_rdata = pv[LAT-1] ? pipe[LAT-1] : 32'h5A5A_5A5A;

  // Reference model state
  logic [31:0] ref_mem [64];
  logic [31:0] exp_rd [2];
  bit          model_last;

  typedef struct {
    bit who; bit we; logic [31:0] adr; logic [31:0] wd;
  } txn_t;

  typedef struct {
    bit r0; bit we0; logic [31:0] a0; logic [31:0] d0;
    bit r1; bit we1; logic [31:0] a1; logic [31:0] d1;
    bit exp_first; int exp_nen;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(input txn_t t);
    if (t.adr[1:0] != 2'b00) return 1;
    if (t.we) return 2;
    return 2 + LAT;
  endfunction

  task automatic do_reset();
    rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ctl", {24'd0, m0_ack, m0_err, m1_ack, m1_err, mem_en, mem_we, owner, busy}, 32'd0);
    chk("rst_data", m0_rdata | m1_rdata | mem_adr | mem_wdata, 32'd0);
    rst = 1'b1;
    model_last = 1'b1;
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
  endtask

  // Applies one or two simultaneous requests and follows them to completion
  task automatic serve(input vec_t v, input string nm);
    txn_t q [2];
    txn_t t0, t1;
    int nq, idx, start, nen;
    t0 = '{who: 1'b0, we: v.we0, adr: v.a0, wd: v.d0};
    t1 = '{who: 1'b1, we: v.we1, adr: v.a1, wd: v.d1};
    if (v.r0 && v.r1) begin
      q[0] = v.exp_first ? t1 : t0;
      q[1] = v.exp_first ? t0 : t1;
      nq = 2;
    end else begin
      q[0] = v.r1 ? t1 : t0;
      nq = 1;
    end
    m0_we = v.we0; m0_adr = v.a0; m0_wdata = v.d0; m0_req = v.r0;
    m1_we = v.we1; m1_adr = v.a1; m1_wdata = v.d1; m1_req = v.r1;
    start = cyc; idx = 0; nen = 0;
    for (int c = 0; c < 64 && idx < nq; c++) begin
      @(negedge clk);
      if (mem_en) begin
        nen++;
        chk({nm, "_en_aligned"}, {30'd0, q[idx].adr[1:0]}, 32'd0);
        chk({nm, "_en_time"}, cyc, start + 1);
        chk({nm, "_mem_adr"}, mem_adr, q[idx].adr);
        chk({nm, "_mem_we"}, {31'd0, mem_we}, {31'd0, q[idx].we});
        if (q[idx].we) chk({nm, "_mem_wdata"}, mem_wdata, q[idx].wd);
      end
      if (m0_ack || m1_ack) begin
        txn_t t;
        t = q[idx];
        chk({nm, "_ack_overlap"}, {31'd0, m0_ack && m1_ack}, 32'd0);
        chk({nm, "_ack_who"}, {31'd0, m1_ack}, {31'd0, t.who});
        chk({nm, "_ack_time"}, cyc, start + lat_of(t));
        chk({nm, "_err"}, {31'd0, m0_err | m1_err}, {31'd0, t.adr[1:0] != 2'b00});
        chk({nm, "_owner"}, {31'd0, owner}, {31'd0, t.who});
        if (t.adr[1:0] == 2'b00) begin
          if (t.we) ref_mem[t.adr[7:2]] = t.wd;
          else exp_rd[t.who] = ref_mem[t.adr[7:2]];
        end
        chk({nm, "_m0_rdata"}, m0_rdata, exp_rd[0]);
        chk({nm, "_m1_rdata"}, m1_rdata, exp_rd[1]);
        model_last = t.who;
        if (t.who) m1_req = 1'b0; else m0_req = 1'b0;
        idx++;
        start = cyc + 1;
      end
    end
    chk({nm, "_completed"}, idx, nq);
    m0_req = 1'b0; m1_req = 1'b0;
    chk({nm, "_nen"}, nen, v.exp_nen);
    @(negedge clk);
    chk({nm, "_idle"}, {30'd0, busy, mem_en}, 32'd0);
  endtask

  function automatic logic [31:0] hadr(input bit who, input int k);
    if (who) return 32'h80 + 4 * k;
    if (k == 0) return 32'h10;
    return 32'h40 + 4 * k;
  endfunction

  // Requesters keep req high through acks; each ack moves that requester to its next address
  task automatic hold_seq(input bit h0, input bit h1, input int n, input string nm);
    int k [2];
    int start, nen, done;
    bit who, last, seen;
    k[0] = 0; k[1] = 0;
    m0_we = 1'b0; m1_we = 1'b0; m0_wdata = 32'd0; m1_wdata = 32'd0;
    m0_adr = hadr(1'b0, 0); m1_adr = hadr(1'b1, 0);
    m0_req = h0; m1_req = h1;
    start = cyc; nen = 0; last = model_last; done = 0;
    for (int j = 0; j < n; j++) begin
      logic [31:0] a;
      who = (h0 && h1) ? !last : h1;
      a = hadr(who, k[who]);
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(negedge clk);
        if (mem_en) begin
          nen++;
          chk({nm, "_mem_adr"}, mem_adr, a);
          chk({nm, "_en_time"}, cyc, start + 1);
        end
        if (m0_ack || m1_ack) seen = 1'b1;
      end
      chk({nm, "_ack_seen"}, {31'd0, seen}, 32'd1);
      chk({nm, "_ack_overlap"}, {31'd0, m0_ack && m1_ack}, 32'd0);
      chk({nm, "_ack_who"}, {31'd0, m1_ack}, {31'd0, who});
      chk({nm, "_owner"}, {31'd0, owner}, {31'd0, who});
      chk({nm, "_ack_time"}, cyc, start + 2 + LAT);
      exp_rd[who] = ref_mem[a[7:2]];
      chk({nm, "_rdata"}, who ? m1_rdata : m0_rdata, exp_rd[who]);
      last = who;
      k[who]++;
      if (who) m1_adr = hadr(1'b1, k[1]); else m0_adr = hadr(1'b0, k[0]);
      start = cyc + 1;
      done++;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    model_last = last;
    chk({nm, "_nen"}, nen, done);
    @(negedge clk);
  endtask

  vec_t tbl [10];

  initial begin
    vec_t v;
    int n_ack;
    m0_req = 1'b0; m0_we = 1'b0; m0_adr = 32'd0; m0_wdata = 32'd0;
    m1_req = 1'b0; m1_we = 1'b0; m1_adr = 32'd0; m1_wdata = 32'd0;
    rst = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_pat(i);

    tbl[0] = '{1'b1, 1'b0, 32'h10, 32'h0,         1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1};
    tbl[1] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b1, 1};
    tbl[2] = '{1'b1, 1'b0, 32'h3,  32'h0,         1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 0};
    tbl[3] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'h20, 32'h0,         1'b1, 1};
    tbl[4] = '{1'b1, 1'b1, 32'h30, 32'hAAAA_5555, 1'b1, 1'b0, 32'h30, 32'h0,         1'b0, 2};
    tbl[5] = '{1'b1, 1'b0, 32'h44, 32'h0,         1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1};
    tbl[6] = '{1'b1, 1'b0, 32'h40, 32'h0,         1'b1, 1'b1, 32'h40, 32'h0BAD_F00D, 1'b1, 2};
    tbl[7] = '{1'b1, 1'b0, 32'h41, 32'h0,         1'b1, 1'b1, 32'h22, 32'h11,        1'b1, 0};
    tbl[8] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'h07, 32'h0,         1'b1, 0};
    tbl[9] = '{1'b1, 1'b1, 32'h08, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h08, 32'h0,         1'b0, 2};

    do_reset();
    for (int i = 0; i < 10; i++) serve(tbl[i], $sformatf("vec%0d", i));

    hold_seq(1'b1, 1'b0, 2, "m0_hold");
    do_reset();
    hold_seq(1'b1, 1'b1, 4, "fair");

    // Reset while an m1 read sits in WAIT: no ack, then a clean reissue
    m1_we = 1'b0; m1_adr = 32'h20; m1_req = 1'b1;
    @(negedge clk);
    m1_req = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ctl", {24'd0, m0_ack, m0_err, m1_ack, m1_err, mem_en, mem_we, owner, busy}, 32'd0);
    chk("midrst_data", m0_rdata | m1_rdata | mem_adr | mem_wdata, 32'd0);
    rst = 1'b1;
    model_last = 1'b1; exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
    n_ack = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) n_ack++;
    end
    chk("midrst_no_ack", n_ack, 0);
    v = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1};
    serve(v, "reissue");

    for (int i = 0; i < 150; i++) begin
      v.r0 = 1'($urandom_range(0, 1)); v.r1 = 1'($urandom_range(0, 1));
      if (!v.r0 && !v.r1) v.r0 = 1'b1;
      v.we0 = 1'($urandom_range(0, 1)); v.we1 = 1'($urandom_range(0, 1));
      v.a0 = 32'($urandom_range(0, 255)); v.a1 = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) v.a0[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 0) v.a1[1:0] = 2'b00;
      v.d0 = $urandom; v.d1 = $urandom;
      v.exp_first = (v.r0 && v.r1) ? !model_last : v.r1;
      v.exp_nen = int'(v.r0 && v.a0[1:0] == 2'b00) + int'(v.r1 && v.a1[1:0] == 2'b00);
      serve(v, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
